// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and field widths for the game sequencer.
package game_pkg;
  typedef enum logic [2:0] {
    TITLE       = 3'd0,
    PLAYING     = 3'd1,
    LEVEL_CLEAR = 3'd2,
    GAME_OVER   = 3'd3,
    WIN         = 3'd4
  } game_state_t;
  localparam int LIVES_W     = 2;
  localparam int LEVEL_W     = 2;
  localparam int KILLS_W     = 4;
  localparam int FRAME_CNT_W = 8;
endpackage

// File: rtl/frame_countdown.sv
// frame_countdown: loadable down-counter stepped by frame ticks, saturating at zero.
module frame_countdown
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic [FRAME_CNT_W-1:0] load_val,
  input  logic                   tick,
  output logic                   busy,
  output logic                   done_pulse
);
  logic [FRAME_CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && busy) cnt <= cnt - 1'b1;
  assign busy = cnt != '0;
  // a load on the same edge overrides the tick, so that tick is not counted
  assign done_pulse = tick && !load && cnt == FRAME_CNT_W'(1);
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer tracking lives, level and kill quota.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT        = 3,
  parameter int NUM_LEVELS        = 3,
  parameter int ENEMIES_PER_LEVEL = 8,
  parameter int CLEAR_FRAMES      = 120,
  parameter int INVULN_FRAMES     = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               player_hit,
  input  logic               enemy_killed,
  output logic               play_en,
  output logic               level_start,
  output logic               gameOver,
  output logic               win,
  output logic               invuln,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic [KILLS_W-1:0] kills_left
);
  game_state_t state, state_nx;
  logic [LIVES_W-1:0] lives_nx;
  logic [LEVEL_W-1:0] level_nx;
  logic [KILLS_W-1:0] kills_nx;
  logic [FRAME_CNT_W-1:0] inv_val;
  logic inv_load, clr_load, clr_done, clr_busy, inv_done, unused;
  logic hit_ok, fatal, kill_ok;
  assign hit_ok  = player_hit && !invuln;
  assign fatal   = hit_ok && lives == LIVES_W'(1);
  assign kill_ok = enemy_killed && kills_left != '0 && !fatal;
  assign unused  = ^{inv_done, clr_busy};
  frame_countdown u_clear (
    .clk(clk), .resetN(resetN), .load(clr_load), .load_val(FRAME_CNT_W'(CLEAR_FRAMES)),
    .tick(frame_tick && state == LEVEL_CLEAR), .busy(clr_busy), .done_pulse(clr_done)
  );
  frame_countdown u_invuln (
    .clk(clk), .resetN(resetN), .load(inv_load), .load_val(inv_val),
    .tick(frame_tick && state == PLAYING), .busy(invuln), .done_pulse(inv_done)
  );
  always_comb begin
    state_nx = state;
    lives_nx = lives;
    level_nx = level;
    kills_nx = kills_left;
    inv_load = 1'b0;
    inv_val  = '0;
    clr_load = 1'b0;
    case (state)
      TITLE: if (start) begin
        state_nx = PLAYING;
        lives_nx = LIVES_W'(LIVES_INIT);
        level_nx = '0;
        kills_nx = KILLS_W'(ENEMIES_PER_LEVEL);
        inv_load = 1'b1;
      end
      PLAYING: if (fatal) begin
        state_nx = GAME_OVER;
        lives_nx = '0;
      end else begin
        if (hit_ok) begin
          lives_nx = lives - 1'b1;
          inv_load = 1'b1;
          inv_val  = FRAME_CNT_W'(INVULN_FRAMES);
        end
        if (kill_ok) begin
          kills_nx = kills_left - 1'b1;
          if (kills_left == KILLS_W'(1)) begin
            state_nx = level == LEVEL_W'(NUM_LEVELS - 1) ? WIN : LEVEL_CLEAR;
            clr_load = level != LEVEL_W'(NUM_LEVELS - 1);
          end
        end
      end
      LEVEL_CLEAR: if (clr_done) begin
        state_nx = PLAYING;
        level_nx = level + 1'b1;
        kills_nx = KILLS_W'(ENEMIES_PER_LEVEL);
        inv_load = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state       <= TITLE;
      lives       <= '0;
      level       <= '0;
      kills_left  <= '0;
      play_en     <= 1'b0;
      level_start <= 1'b0;
      gameOver    <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_nx;
      lives       <= lives_nx;
      level       <= level_nx;
      kills_left  <= kills_nx;
      play_en     <= state_nx == PLAYING;
      level_start <= state_nx == PLAYING && state != PLAYING;
      gameOver    <= state_nx == GAME_OVER;
      win         <= state_nx == WIN;
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed plan plus random play checked against a rule-level game model.
module tb_game_flow_ctrl;
  localparam int LI = 3, NL = 3, EPL = 8, CF = 120, IF = 60;
  logic clk = 1'b0, resetN = 1'b0;
  logic start = 1'b0, frame_tick = 1'b0, player_hit = 1'b0, enemy_killed = 1'b0;
  logic play_en, level_start, gameOver, win, invuln;
  logic [1:0] level, lives;
  logic [3:0] kills_left;
  int n_vec = 0, n_err = 0;
  // model: mode 0 title, 1 playing, 2 clear pause, 3 lost, 4 won
  int m_mode, m_lives, m_level, m_kills, m_clr, m_inv;
  bit m_ls;

  game_flow_ctrl #(.LIVES_INIT(LI), .NUM_LEVELS(NL), .ENEMIES_PER_LEVEL(EPL),
                   .CLEAR_FRAMES(CF), .INVULN_FRAMES(IF)) dut (
    .clk(clk), .resetN(resetN), .start(start), .frame_tick(frame_tick),
    .player_hit(player_hit), .enemy_killed(enemy_killed), .play_en(play_en),
    .level_start(level_start), .gameOver(gameOver), .win(win), .invuln(invuln),
    .level(level), .lives(lives), .kills_left(kills_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("play_en", 8'(play_en), 8'(m_mode == 1));
    chk("level_start", 8'(level_start), 8'(m_ls));
    chk("gameOver", 8'(gameOver), 8'(m_mode == 3));
    chk("win", 8'(win), 8'(m_mode == 4));
    chk("invuln", 8'(invuln), 8'(m_inv != 0));
    chk("level", 8'(level), 8'(m_level));
    chk("lives", 8'(lives), 8'(m_lives));
    chk("kills_left", 8'(kills_left), 8'(m_kills));
  endtask

  task automatic model_reset();
    m_mode = 0; m_lives = 0; m_level = 0; m_kills = 0; m_clr = 0; m_inv = 0; m_ls = 0;
  endtask

  task automatic model_step(input bit s, input bit ft, input bit ph, input bit ek);
    bit hit;
    m_ls = 0;
    if (m_mode == 0) begin
      if (s) begin
        m_mode = 1; m_lives = LI; m_level = 0; m_kills = EPL; m_inv = 0; m_ls = 1;
      end
    end else if (m_mode == 1) begin
      hit = ph && m_inv == 0;
      if (hit && m_lives == 1) begin
        m_lives = 0; m_mode = 3;
      end else begin
        if (hit) begin
          m_lives--; m_inv = IF;
        end else if (ft && m_inv > 0) m_inv--;
        if (ek && m_kills > 0) begin
          m_kills--;
          if (m_kills == 0) begin
            if (m_level == NL - 1) m_mode = 4;
            else begin
              m_mode = 2; m_clr = CF;
            end
          end
        end
      end
    end else if (m_mode == 2 && ft) begin
      m_clr--;
      if (m_clr == 0) begin
        m_mode = 1; m_level++; m_kills = EPL; m_inv = 0; m_ls = 1;
      end
    end
  endtask

  task automatic step(input bit s, input bit ft, input bit ph, input bit ek);
    start = s; frame_tick = ft; player_hit = ph; enemy_killed = ek;
    @(posedge clk);
    model_step(s, ft, ph, ek);
    #1;
    start = 0; frame_tick = 0; player_hit = 0; enemy_killed = 0;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) step(0, 1, 0, 0);
  endtask

  task automatic do_reset();
    #2 resetN = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) resetN = 1'b1;
  endtask

  task automatic kills(input int n);
    repeat (n) step(0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #3 check_all();
    @(negedge clk) resetN = 1'b1;
    // full run to WIN
    step(1, 0, 0, 0);
    chk("t1_play_en", 8'(play_en), 8'd1);
    chk("t1_lives", 8'(lives), 8'd3);
    chk("t1_kills", 8'(kills_left), 8'd8);
    chk("t1_level_start", 8'(level_start), 8'd1);
    step(0, 0, 0, 0);
    chk("t1_level_start_one", 8'(level_start), 8'd0);
    for (int lv = 0; lv < NL; lv++) begin
      kills(EPL);
      if (lv < NL - 1) begin
        chk("t2_in_clear", 8'(play_en), 8'd0);
        ticks(CF - 1);
        chk("t2_still_clear", 8'(level), 8'(lv));
        ticks(1);
        chk("t2_level", 8'(level), 8'(lv + 1));
        chk("t2_level_start", 8'(level_start), 8'd1);
      end
    end
    chk("t2_win", 8'(win), 8'd1);
    chk("t2_play_en", 8'(play_en), 8'd0);
    // invulnerability window and game over by hits
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("t3_hit1", 8'(lives), 8'd2);
    ticks(10);
    step(0, 0, 1, 0);
    chk("t3_ignored", 8'(lives), 8'd2);
    ticks(IF - 11);
    chk("t3_inv_edge", 8'(invuln), 8'd1);
    ticks(1);
    chk("t3_inv_end", 8'(invuln), 8'd0);
    step(0, 0, 1, 0);
    chk("t3_hit2", 8'(lives), 8'd1);
    ticks(IF);
    step(0, 0, 1, 0);
    chk("t3_over", 8'(gameOver), 8'd1);
    chk("t3_lives0", 8'(lives), 8'd0);
    // fatal hit coinciding with the last kill
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    ticks(IF);
    step(0, 0, 1, 0);
    ticks(IF);
    kills(EPL - 1);
    step(0, 0, 1, 1);
    chk("t4_over", 8'(gameOver), 8'd1);
    chk("t4_win", 8'(win), 8'd0);
    chk("t4_kills", 8'(kills_left), 8'd1);
    // terminal state ignores inputs
    step(1, 1, 1, 1);
    step(1, 0, 0, 1);
    chk("t5_hold", 8'(gameOver), 8'd1);
    // asynchronous reset during the clear pause
    do_reset();
    step(1, 0, 0, 0);
    kills(EPL);
    ticks(30);
    do_reset();
    chk("t5_reset_kills", 8'(kills_left), 8'd0);
    // random games
    for (int g = 0; g < 6; g++) begin
      do_reset();
      step(1, 0, 0, 0);
      for (int c = 0; c < 4000 && m_mode < 3; c++)
        step($urandom_range(49) == 0, $urandom_range(2) == 0,
             $urandom_range(g < 3 ? 29 : 299) == 0, $urandom_range(5) == 0);
      repeat (20)
        step($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for Space Adventure. Tracks lives, level and per-level kill quota. Drives the `gameOver` and `win` inputs of the end-of-game message state machine, and gates gameplay logic through `play_en`. Sits between the key/collision event sources and the message/drawing blocks, and is timed by the per-frame tick from the VGA controller.

## Interface

**Parameters**
- LIVES_INIT, 3: lives at game start (1..3).
- NUM_LEVELS, 3: number of levels (1..4).
- ENEMIES_PER_LEVEL, 8: kills required to clear a level (1..15).
- CLEAR_FRAMES, 120: frame ticks spent in the level-clear pause (1..255).
- INVULN_FRAMES, 60: frame ticks of invulnerability after a hit (1..255).

**Ports**
- Clock and reset (already decided): reset resetN, asynchronous, active-low; clock clk.
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous active-low reset; the only way out of GAME_OVER/WIN.
- start, in, 1: one-cycle debounced start-key pulse.
- frame_tick, in, 1: one-cycle pulse per video frame.
- player_hit, in, 1: one-cycle pulse, player collided with enemy or shot.
- enemy_killed, in, 1: one-cycle pulse, one enemy destroyed.
- play_en, out, 1: high while in PLAYING.
- level_start, out, 1: one-cycle pulse on every entry to PLAYING.
- gameOver, out, 1: high while in GAME_OVER.
- win, out, 1: high while in WIN.
- invuln, out, 1: high while the invulnerability countdown is nonzero.
- level, out, 2: current level index, 0-based.
- lives, out, 2: remaining lives.
- kills_left, out, 4: kills still needed in the current level.

## Operation

**States:** TITLE, PLAYING, LEVEL_CLEAR, GAME_OVER, WIN.

**TITLE**
- On `start`: load lives=LIVES_INIT, level=0, kills_left=ENEMIES_PER_LEVEL, clear invuln, go to PLAYING.
- All other inputs are ignored.

**PLAYING: hits**
- `player_hit` with invuln=0 and lives>1: lives−1, load the invuln counter with INVULN_FRAMES.
- `player_hit` with invuln=0 and lives==1: lives←0, go to GAME_OVER.
- `player_hit` with invuln=1 is ignored.

**PLAYING: kills**
- `enemy_killed`: kills_left−1.
- When that decrement reaches 0:
  - if level==NUM_LEVELS−1, go to WIN;
  - otherwise load the clear counter with CLEAR_FRAMES and go to LEVEL_CLEAR.

**PLAYING: simultaneous events**
- A fatal hit and a kill in the same cycle: GAME_OVER wins, and kills_left is not decremented.
- A non-fatal hit and a kill in the same cycle: both are applied. The level-clear/WIN transition still occurs, and lives keeps its decremented value.

**LEVEL_CLEAR**
- Hits and kills are ignored.
- The clear counter decrements on each `frame_tick`.
- On the tick that takes it 1→0: level+1, kills_left←ENEMIES_PER_LEVEL, invuln cleared, go to PLAYING.

**GAME_OVER / WIN**
- Terminal: all inputs, including `start`, are ignored until resetN.
- lives, level and kills_left hold their final values.

**Invuln counter**
- Decrements only on `frame_tick` while in PLAYING, and saturates at 0.

**Counters**
- Counters never wrap.
- `enemy_killed` when kills_left==0 cannot occur in PLAYING; if it does, it is ignored.

## Timing

- All outputs are registered. An input sampled at rising edge N produces its state and output change visible after edge N, i.e. in cycle N+1.
- `level_start` is high for exactly the one cycle following the transition edge.
- Values after reset:
  - state=TITLE
  - play_en=0, level_start=0, gameOver=0, win=0, invuln=0
  - level=0, lives=0, kills_left=0
  - both internal counters at 0
- Asynchronous reset mid-operation (any state) returns immediately to the values above. No output glitch high is permitted on reset assertion.
- Invulnerability ends exactly INVULN_FRAMES frame ticks after the hit. invuln falls after the edge that samples the INVULN_FRAMES-th tick.
- `frame_tick` coinciding with the hit edge does not count toward the invulnerability window.

## Structure

- Shared package `game_pkg` holds:
  - `typedef enum logic [2:0] game_state_t` (the five states);
  - width localparams LIVES_W=2, LEVEL_W=2, KILLS_W=4, FRAME_CNT_W=8.
- Sub-module `frame_countdown`: 8-bit down-counter with ports load, load_val, tick, busy and done_pulse, saturating at 0. It is instantiated twice, once for the clear pause and once for invulnerability.

## Test plan

1. Reset, then `start` → play_en=1, lives=3, level=0, kills_left=8, and `level_start` high for 1 cycle.
2. 8 `enemy_killed` pulses in level 0 → LEVEL_CLEAR. After 120 `frame_tick` pulses: level=1, kills_left=8, `level_start` pulses. Repeat through level 2 → win=1, play_en=0.
3. `player_hit`, then a second hit before 60 ticks → lives=2 (second hit ignored). After 60 ticks a further hit → lives=1. The next hit after 60 ticks → gameOver=1, lives=0.
4. With lives=1, invuln=0 and kills_left=1, `player_hit` and `enemy_killed` in the same cycle → gameOver=1, win=0, kills_left=1.
5. In GAME_OVER, apply `start` and `enemy_killed` → no change. Assert resetN low mid-LEVEL_CLEAR → all outputs take their reset values asynchronously.
